// File: rtl/elastic_skp_ctrl.sv
// Read-side elastic buffer controller: priming, SKP add/remove for clock compensation, over/underflow recovery.
// Optional SKP statistics counters are built when ELASTIC_SKP_STATS_EN is defined.
module elastic_skp_ctrl #(
    parameter int DEPTH    = 16,
    parameter int PRIME_TH = 8,
    parameter int HI_TH    = 12,
    parameter int LO_TH    = 4
) (
    input  logic                   CLK,
    input  logic                   Rst,
    input  logic [$clog2(DEPTH):0] Fill_Level,
    input  logic                   Rd_Sym_Com,
    input  logic                   Rd_Sym_Skp,
    output logic                   Rd_En,
    output logic                   Skp_Insert,
    output logic                   Rx_Data_Valid,
    output logic                   Flush,
    output logic                   Skp_Added,
    output logic                   Skp_Removed,
    output logic                   Overflow,
    output logic                   Underflow
`ifdef ELASTIC_SKP_STATS_EN
    ,
    output logic [7:0]             Skp_Add_Cnt,
    output logic [7:0]             Skp_Rem_Cnt
`endif
);

    localparam int FW = $clog2(DEPTH) + 1;
    localparam logic [FW-1:0] DEPTH_F    = FW'(DEPTH);
    localparam logic [FW-1:0] PRIME_TH_F = FW'(PRIME_TH);
    localparam logic [FW-1:0] HI_TH_F    = FW'(HI_TH);
    localparam logic [FW-1:0] LO_TH_F    = FW'(LO_TH);

    typedef enum logic [1:0] {
        FLUSH  = 2'd0,
        PRIME  = 2'd1,
        RUN    = 2'd2,
        SKP_OS = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic fill_over;
    logic fill_under;
    logic fill_nonzero;
    logic active;
    logic ovf_evt;
    logic unf_evt;
    logic rem_evt;
    logic add_evt;

    // Anything above DEPTH is a corrupted occupancy and is handled like a full buffer.
    assign fill_over    = (Fill_Level >= DEPTH_F);
    assign fill_under   = (Fill_Level == '0);
    assign fill_nonzero = !fill_under;
    assign active       = (state == RUN) || (state == SKP_OS);

    assign ovf_evt = !Rst && active && fill_over;
    assign unf_evt = !Rst && active && fill_under;
    assign rem_evt = !Rst && (state == SKP_OS) && Rd_Sym_Skp && !fill_over && !fill_under
                     && (Fill_Level >= HI_TH_F);
    assign add_evt = !Rst && (state == SKP_OS) && Rd_Sym_Skp && !fill_over && !fill_under
                     && (Fill_Level <= LO_TH_F) && (Fill_Level < HI_TH_F);

    always_ff @(posedge CLK) begin
        if (Rst) begin
            state <= FLUSH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FLUSH: begin
                next_state = PRIME;
            end
            PRIME: begin
                if (Fill_Level >= PRIME_TH_F) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (fill_over || fill_under) begin
                    next_state = FLUSH;
                end else if (Rd_Sym_Com) begin
                    next_state = SKP_OS;
                end
            end
            SKP_OS: begin
                // Only the first SKP after a COM may be adjusted, so always fall back to RUN.
                if (fill_over || fill_under) begin
                    next_state = FLUSH;
                end else begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = FLUSH;
            end
        endcase
    end

    always_comb begin
        Rd_En         = 1'b0;
        Skp_Insert    = 1'b0;
        Rx_Data_Valid = 1'b0;
        Flush         = Rst;
        if (!Rst) begin
            case (state)
                FLUSH: begin
                    Flush = 1'b1;
                end
                PRIME: begin
                    Flush = 1'b0;
                end
                RUN, SKP_OS: begin
                    if (rem_evt) begin
                        Rd_En = 1'b1;
                    end else if (add_evt) begin
                        Skp_Insert    = 1'b1;
                        Rx_Data_Valid = 1'b1;
                    end else begin
                        Rd_En         = fill_nonzero;
                        Rx_Data_Valid = fill_nonzero;
                    end
                end
                default: begin
                    Flush = 1'b1;
                end
            endcase
        end
    end

    // Event pulses trail the deciding cycle by one clock; the deciding terms are mutually exclusive.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            Skp_Added   <= 1'b0;
            Skp_Removed <= 1'b0;
            Overflow    <= 1'b0;
            Underflow   <= 1'b0;
        end else begin
            Skp_Added   <= add_evt;
            Skp_Removed <= rem_evt;
            Overflow    <= ovf_evt;
            Underflow   <= unf_evt && !ovf_evt;
        end
    end

`ifdef ELASTIC_SKP_STATS_EN
    always_ff @(posedge CLK) begin
        if (Rst) begin
            Skp_Add_Cnt <= 8'd0;
            Skp_Rem_Cnt <= 8'd0;
        end else begin
            if (Skp_Added && (Skp_Add_Cnt != 8'hFF)) begin
                Skp_Add_Cnt <= Skp_Add_Cnt + 8'd1;
            end
            if (Skp_Removed && (Skp_Rem_Cnt != 8'hFF)) begin
                Skp_Rem_Cnt <= Skp_Rem_Cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_elastic_skp_ctrl.sv
// Self-checking bench for elastic_skp_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the controller's rules.
module tb_elastic_skp_ctrl;

    localparam int DEPTH    = 16;
    localparam int PRIME_TH = 8;
    localparam int HI_TH    = 12;
    localparam int LO_TH    = 4;

    logic       CLK = 1'b0;
    logic       Rst;
    logic [4:0] Fill_Level;
    logic       Rd_Sym_Com;
    logic       Rd_Sym_Skp;
    logic       Rd_En;
    logic       Skp_Insert;
    logic       Rx_Data_Valid;
    logic       Flush;
    logic       Skp_Added;
    logic       Skp_Removed;
    logic       Overflow;
    logic       Underflow;
`ifdef ELASTIC_SKP_STATS_EN
    logic [7:0] Skp_Add_Cnt;
    logic [7:0] Skp_Rem_Cnt;
`endif

    int assert_cnt = 0;
    int fail_cnt   = 0;

    // Model state: phase flags rather than a state encoding
    bit m_flushing;
    bit m_priming;
    bit m_after_com;
    bit exp_added;
    bit exp_removed;
    bit exp_ovf;
    bit exp_unf;
    int m_add_cnt;
    int m_rem_cnt;

    elastic_skp_ctrl #(
        .DEPTH(DEPTH),
        .PRIME_TH(PRIME_TH),
        .HI_TH(HI_TH),
        .LO_TH(LO_TH)
    ) dut (
        .CLK(CLK),
        .Rst(Rst),
        .Fill_Level(Fill_Level),
        .Rd_Sym_Com(Rd_Sym_Com),
        .Rd_Sym_Skp(Rd_Sym_Skp),
        .Rd_En(Rd_En),
        .Skp_Insert(Skp_Insert),
        .Rx_Data_Valid(Rx_Data_Valid),
        .Flush(Flush),
        .Skp_Added(Skp_Added),
        .Skp_Removed(Skp_Removed),
        .Overflow(Overflow),
        .Underflow(Underflow)
`ifdef ELASTIC_SKP_STATS_EN
        ,
        .Skp_Add_Cnt(Skp_Add_Cnt),
        .Skp_Rem_Cnt(Skp_Rem_Cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput(input bit rst, input bit e_rd, input bit e_ins, input bit e_val,
                               input bit e_flush);
        checkVal("rd_en", {7'd0, Rd_En}, {7'd0, e_rd});
        checkVal("skp_insert", {7'd0, Skp_Insert}, {7'd0, e_ins});
        checkVal("rx_data_valid", {7'd0, Rx_Data_Valid}, {7'd0, e_val});
        if (!rst) checkVal("flush", {7'd0, Flush}, {7'd0, e_flush});
        checkVal("skp_added", {7'd0, Skp_Added}, {7'd0, exp_added});
        checkVal("skp_removed", {7'd0, Skp_Removed}, {7'd0, exp_removed});
        checkVal("overflow", {7'd0, Overflow}, {7'd0, exp_ovf});
        checkVal("underflow", {7'd0, Underflow}, {7'd0, exp_unf});
`ifdef ELASTIC_SKP_STATS_EN
        checkVal("skp_add_cnt", Skp_Add_Cnt, 8'(m_add_cnt));
        checkVal("skp_rem_cnt", Skp_Rem_Cnt, 8'(m_rem_cnt));
`endif
    endtask

    // One clock cycle: drive inputs, predict and check outputs, then advance the model past the edge.
    task automatic applyStimulus(input bit rst, input int fill, input bit com, input bit skp);
        bit e_rd, e_ins, e_val, e_flush;
        bit over, under, may_adjust, add_now, rem_now;
        @(posedge CLK);
        #1;
        Rst        = rst;
        Fill_Level = 5'(fill);
        Rd_Sym_Com = com;
        Rd_Sym_Skp = skp;
        #2;
        over    = (fill >= DEPTH);
        under   = (fill == 0);
        e_rd    = 0;
        e_ins   = 0;
        e_val   = 0;
        e_flush = m_flushing;
        add_now = 0;
        rem_now = 0;
        if (!rst && !m_flushing && !m_priming) begin
            may_adjust = m_after_com && skp && !over && !under;
            if (may_adjust && fill >= HI_TH) begin
                e_rd    = 1;
                rem_now = 1;
            end else if (may_adjust && fill <= LO_TH) begin
                e_ins   = 1;
                e_val   = 1;
                add_now = 1;
            end else begin
                e_rd  = (fill != 0);
                e_val = (fill != 0);
            end
        end
        checkOutput(rst, e_rd, e_ins, e_val, e_flush);

        if (rst) begin
            m_add_cnt = 0;
            m_rem_cnt = 0;
        end else begin
            if (exp_added && m_add_cnt < 255) m_add_cnt++;
            if (exp_removed && m_rem_cnt < 255) m_rem_cnt++;
        end
        exp_added   = add_now;
        exp_removed = rem_now;
        exp_ovf     = 0;
        exp_unf     = 0;
        if (rst) begin
            m_flushing  = 1;
            m_priming   = 0;
            m_after_com = 0;
        end else if (m_flushing) begin
            m_flushing = 0;
            m_priming  = 1;
        end else if (m_priming) begin
            if (fill >= PRIME_TH) m_priming = 0;
            m_after_com = 0;
        end else if (over || under) begin
            exp_ovf     = over;
            exp_unf     = under;
            m_flushing  = 1;
            m_after_com = 0;
        end else if (m_after_com) begin
            m_after_com = 0;
        end else begin
            m_after_com = com;
        end
    endtask

    task automatic primeToRun();
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, PRIME_TH, 0, 0);
    endtask

    initial begin
        Rst        = 1'b1;
        Fill_Level = '0;
        Rd_Sym_Com = 1'b0;
        Rd_Sym_Skp = 1'b0;
        repeat (2) @(posedge CLK);
        m_flushing  = 1;
        m_priming   = 0;
        m_after_com = 0;
        exp_added   = 0;
        exp_removed = 0;
        exp_ovf     = 0;
        exp_unf     = 0;
        m_add_cnt   = 0;
        m_rem_cnt   = 0;

        // Reset, then fill ramps 0..8 and the first read follows the sampled prime level
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 5, 1, 1);
        for (int f = 0; f <= PRIME_TH; f++) applyStimulus(0, f, 0, 0);
        applyStimulus(0, PRIME_TH, 0, 0);
        checkVal("first_read_after_prime", {7'd0, Rd_En}, 8'd1);

        // High fill: COM then SKP drops the SKP
        applyStimulus(0, 13, 1, 0);
        applyStimulus(0, 13, 0, 1);
        checkVal("skp_dropped_valid", {7'd0, Rx_Data_Valid}, 8'd0);
        applyStimulus(0, 13, 0, 1);
        checkVal("skp_removed_pulse", {7'd0, Skp_Removed}, 8'd1);

        // Low fill: COM then SKP inserts a SKP; the second SKP passes untouched
        applyStimulus(0, 3, 1, 0);
        applyStimulus(0, 3, 0, 1);
        checkVal("skp_insert_seen", {7'd0, Skp_Insert}, 8'd1);
        applyStimulus(0, 3, 0, 1);
        checkVal("skp_added_pulse", {7'd0, Skp_Added}, 8'd1);
        checkVal("second_skp_untouched", {7'd0, Skp_Insert}, 8'd0);

        // Full buffer, then empty buffer, then an out-of-range fill
        applyStimulus(0, DEPTH, 0, 0);
        applyStimulus(0, 10, 0, 0);
        checkVal("overflow_pulse", {7'd0, Overflow}, 8'd1);
        applyStimulus(0, 10, 0, 0);
        applyStimulus(0, PRIME_TH, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkVal("underflow_pulse", {7'd0, Underflow}, 8'd1);
        primeToRun();
        applyStimulus(0, PRIME_TH, 0, 0);
        applyStimulus(0, 20, 1, 1);
        applyStimulus(0, 10, 0, 0);
        checkVal("over_range_overflow", {7'd0, Overflow}, 8'd1);

        // Reset while the removal decision is pending
        primeToRun();
        applyStimulus(0, 13, 0, 0);
        applyStimulus(0, 13, 1, 0);
        applyStimulus(1, 13, 0, 1);
        applyStimulus(0, 13, 0, 0);
        checkVal("reset_kills_removal", {7'd0, Skp_Removed}, 8'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int sel;
            int fill;
            sel = int'($urandom_range(0, 19));
            if (sel == 0) fill = 0;
            else if (sel == 1) fill = DEPTH;
            else if (sel == 2) fill = int'($urandom_range(17, 31));
            else fill = int'($urandom_range(1, 15));
            applyStimulus($urandom_range(0, 99) < 2, fill,
                          $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 5);
        end

`ifdef ELASTIC_SKP_STATS_EN
        // Removal counter saturates
        applyStimulus(1, 0, 0, 0);
        primeToRun();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, 13, 1, 0);
            applyStimulus(0, 13, 0, 1);
        end
        applyStimulus(0, 13, 0, 0);
        applyStimulus(0, 13, 0, 0);
        checkVal("rem_cnt_saturated", Skp_Rem_Cnt, 8'd255);
`endif

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
